uart_core: RTL

- Parametrised full-duplex UART. Successor to the fixed 8N1, 1 Mb/s UART.
- Generalised in:
  - clocks-per-bit
  - data width
  - parity mode
  - stop-bit count
- Adds:
  - independent, concurrent TX and RX paths
  - valid/ready handshakes on both sides
  - framing, parity and overrun error reporting
- Sits between the host/debug link pins and the on-chip loader/MMIO logic.

---
 rtl/uart_pkg.sv | 39 +++
 rtl/uart_bit_timer.sv | 34 +++
 rtl/uart_core.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for uart_core: FSM state encodings, parity modes and the
// parity helper used by both the transmit and receive paths.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_ODD  = 2'd1;
    localparam logic [1:0] PAR_EVEN = 2'd2;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        TX_IDLE   = ST_IDLE,
        TX_START  = ST_START,
        TX_DATA   = ST_DATA,
        TX_PARITY = ST_PARITY,
        TX_STOP   = ST_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE   = ST_IDLE,
        RX_START  = ST_START,
        RX_DATA   = ST_DATA,
        RX_PARITY = ST_PARITY,
        RX_STOP   = ST_STOP
    } rx_state_t;

    // Widest legal payload; narrower payloads are zero-extended, which leaves the XOR unchanged.
    localparam int MAX_DATA_BITS = 9;

    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                         input logic [1:0]               mode);
        return (mode == PAR_ODD) ? ~(^data) : ^data;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: wraps every CLKS_PER_BIT cycles and flags the last cycle
// of each period. A load restarts it at a full or half period.
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 28
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_half,
    output logic o_tick
);

    localparam int            CW      = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LP_LAST = CW'(CLKS_PER_BIT - 1);
    // Starting here leaves exactly CLKS_PER_BIT/2 cycles before the next tick.
    localparam logic [CW-1:0] LP_HALF = CW'(CLKS_PER_BIT - CLKS_PER_BIT / 2);

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == LP_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_half ? LP_HALF : '0;
        end else if (r_cnt == LP_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_core.sv
// Parametrised full-duplex UART with valid/ready handshakes on both paths and
// framing, parity and overrun reporting on the receive side.
module uart_core
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 28,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    output logic                 rx_overrun
);

    localparam logic [1:0] LP_PAR       = 2'(PARITY);
    localparam bit         LP_HAS_PAR   = (PARITY != 0);
    localparam logic [3:0] LP_DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] LP_STOP_LAST = 4'(STOP_BITS - 1);

    // ---------------- transmit path ----------------
    tx_state_t            r_tx_state;
    logic [DATA_BITS-1:0] r_tx_shift;
    logic [3:0]           r_tx_bit;
    logic                 r_tx_par;
    logic                 r_tx;
    logic                 r_tx_ready;
    logic                 w_tx_start;
    logic                 w_tx_tick;

    // tx_ready is only ever high in TX_IDLE, so it alone qualifies the handshake.
    assign w_tx_start = tx_valid && r_tx_ready;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_tx_start),
        .i_half (1'b0),
        .o_tick (w_tx_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_shift <= '0;
            r_tx_bit   <= '0;
            r_tx_par   <= 1'b0;
            r_tx       <= 1'b1;
            r_tx_ready <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: if (w_tx_start) begin
                    r_tx_shift <= tx_data;
                    r_tx_par   <= calc_parity(MAX_DATA_BITS'(tx_data), LP_PAR);
                    r_tx       <= 1'b0;
                    r_tx_ready <= 1'b0;
                    r_tx_state <= TX_START;
                end
                TX_START: if (w_tx_tick) begin
                    r_tx       <= r_tx_shift[0];
                    r_tx_bit   <= '0;
                    r_tx_state <= TX_DATA;
                end
                TX_DATA: if (w_tx_tick) begin
                    if (r_tx_bit == LP_DATA_LAST) begin
                        r_tx_bit <= '0;
                        if (LP_HAS_PAR) begin
                            r_tx       <= r_tx_par;
                            r_tx_state <= TX_PARITY;
                        end else begin
                            r_tx       <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end
                    end else begin
                        r_tx       <= r_tx_shift[1];
                        r_tx_shift <= r_tx_shift >> 1;
                        r_tx_bit   <= r_tx_bit + 1'b1;
                    end
                end
                TX_PARITY: if (w_tx_tick) begin
                    r_tx       <= 1'b1;
                    r_tx_state <= TX_STOP;
                end
                TX_STOP: if (w_tx_tick) begin
                    if (r_tx_bit == LP_STOP_LAST) begin
                        r_tx_ready <= 1'b1;
                        r_tx_state <= TX_IDLE;
                    end else begin
                        r_tx_bit <= r_tx_bit + 1'b1;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign tx       = r_tx;
    assign tx_ready = r_tx_ready;

    // ---------------- receive path ----------------
    logic                 r_rx_meta;
    logic                 r_rx_sync;
    logic                 r_rx_prev;
    rx_state_t            r_rx_state;
    logic [DATA_BITS-1:0] r_rx_shift;
    logic [3:0]           r_rx_bit;
    logic                 r_rx_perr_pend;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_rx_ferr;
    logic                 r_rx_perr;
    logic                 r_rx_ovr;
    logic                 w_rx_fall;
    logic                 w_rx_start;
    logic                 w_rx_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
        end
    end

    // A line held low after a break never shows a falling edge, so no frame restarts until it idles.
    assign w_rx_fall  = r_rx_prev && !r_rx_sync;
    assign w_rx_start = (r_rx_state == RX_IDLE) && w_rx_fall;

    uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx_timer (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_rx_start),
        .i_half (1'b1),
        .o_tick (w_rx_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_state     <= RX_IDLE;
            r_rx_shift     <= '0;
            r_rx_bit       <= '0;
            r_rx_perr_pend <= 1'b0;
            r_rx_data      <= '0;
            r_rx_valid     <= 1'b0;
            r_rx_ferr      <= 1'b0;
            r_rx_perr      <= 1'b0;
            r_rx_ovr       <= 1'b0;
        end else begin
            r_rx_ovr <= 1'b0;
            // NOTE: the non-blocking assignments in the RX_STOP branch below come later in
            // this block, so a frame completing in the same cycle as a consume wins.
            if (r_rx_valid && rx_ready) begin
                r_rx_valid <= 1'b0;
                r_rx_ferr  <= 1'b0;
                r_rx_perr  <= 1'b0;
            end
            case (r_rx_state)
                RX_IDLE: if (w_rx_fall) begin
                    r_rx_perr_pend <= 1'b0;
                    r_rx_state     <= RX_START;
                end
                RX_START: if (w_rx_tick) begin
                    if (r_rx_sync) begin
                        r_rx_state <= RX_IDLE;
                    end else begin
                        r_rx_bit   <= '0;
                        r_rx_state <= RX_DATA;
                    end
                end
                RX_DATA: if (w_rx_tick) begin
                    r_rx_shift <= {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_bit == LP_DATA_LAST) begin
                        r_rx_state <= LP_HAS_PAR ? RX_PARITY : RX_STOP;
                    end else begin
                        r_rx_bit <= r_rx_bit + 1'b1;
                    end
                end
                RX_PARITY: if (w_rx_tick) begin
                    r_rx_perr_pend <= (r_rx_sync != calc_parity(MAX_DATA_BITS'(r_rx_shift), LP_PAR));
                    r_rx_state     <= RX_STOP;
                end
                RX_STOP: if (w_rx_tick) begin
                    r_rx_state <= RX_IDLE;
                    if (!r_rx_valid || rx_ready) begin
                        r_rx_data  <= r_rx_shift;
                        r_rx_valid <= 1'b1;
                        r_rx_ferr  <= !r_rx_sync;
                        r_rx_perr  <= r_rx_perr_pend;
                    end else begin
                        r_rx_ovr <= 1'b1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign rx_data       = r_rx_data;
    assign rx_valid      = r_rx_valid;
    assign rx_frame_err  = r_rx_ferr;
    assign rx_parity_err = r_rx_perr;
    assign rx_overrun    = r_rx_ovr;

endmodule
